// File: rtl/btb_predictor.sv
// Direct-mapped BTB + 2-bit predictor; optional counters under BTB_STATS_EN.
// Latency: 1 cycle, lookup to pred_*. Backpressure: none; updates dropped while busy.
module btb_predictor #(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        lk_valid,
    input  logic [31:0] lk_pc,
    input  logic        flush,
    output logic        pred_valid,
    output logic [31:0] pred_pc,
    output logic        pred_taken,
    output logic [31:0] pred_npc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [1:0]  upd_kind,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        inv_req,
`ifdef BTB_STATS_EN
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_mispred,
`endif
    output logic        busy
);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [29:0]        r_target [ENTRIES];
    logic [1:0]         r_kind   [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic        r_pred_valid, r_pred_taken;
    logic [31:0] r_pred_pc, r_pred_npc;

    logic [IDX_W-1:0] w_lk_idx, w_up_idx;
    logic [TAG_W-1:0] w_lk_tag, w_up_tag;
    logic             w_lk_hit, w_up_hit, w_lk_taken, w_idle;
    logic [31:0]      w_lk_npc;
    logic             w_upd_en, w_write, w_clr;
    logic [1:0]       w_new_ctr;
    logic [29:0]      w_new_target;
    logic             w_unused;

    assign w_idle   = (r_state == S_IDLE);
    assign w_lk_idx = lk_pc[IDX_W+1:2];
    assign w_lk_tag = lk_pc[31:IDX_W+2];
    assign w_up_idx = upd_pc[IDX_W+1:2];
    assign w_up_tag = upd_pc[31:IDX_W+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_unused = ^{lk_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    // Lookups during CLEAR still answer, but always as a miss.
    assign w_lk_taken = w_idle && w_lk_hit &&
                        ((r_kind[w_lk_idx] != 2'b01) || r_ctr[w_lk_idx][1]);
    assign w_lk_npc   = w_lk_taken ? {r_target[w_lk_idx], 2'b00} : lk_pc + 32'd4;

    // A same-cycle inv_req wins over the update.
    assign w_upd_en = upd_valid && w_idle && !inv_req;

    always_comb begin
        w_write      = 1'b0;
        w_clr        = 1'b0;
        w_new_ctr    = r_ctr[w_up_idx];
        w_new_target = r_target[w_up_idx];
        if (w_upd_en) begin
            case (upd_kind)
                2'b00: w_clr = w_up_hit;
                2'b01: begin
                    if (w_up_hit) begin
                        w_write = 1'b1;
                        if (upd_taken) begin
                            w_new_ctr    = (r_ctr[w_up_idx] == 2'b11) ? 2'b11 : r_ctr[w_up_idx] + 2'd1;
                            w_new_target = upd_target[31:2];
                        end else begin
                            w_new_ctr = (r_ctr[w_up_idx] == 2'b00) ? 2'b00 : r_ctr[w_up_idx] - 2'd1;
                        end
                    end else if (upd_taken) begin
                        w_write      = 1'b1;
                        w_new_ctr    = 2'b10;
                        w_new_target = upd_target[31:2];
                    end
                end
                default: begin
                    w_write      = 1'b1;
                    w_new_ctr    = 2'b11;
                    w_new_target = upd_target[31:2];
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (inv_req) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == IDX_W'(ENTRIES - 1)) w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
        end else if (!w_idle) begin
            r_valid[r_ptr] <= 1'b0;
        end else if (w_clr) begin
            r_valid[w_up_idx] <= 1'b0;
        end else if (w_write) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    // Entry payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= w_new_target;
            r_kind[w_up_idx]   <= upd_kind;
            r_ctr[w_up_idx]    <= w_new_ctr;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_pc    <= '0;
            r_pred_npc   <= '0;
        end else begin
            r_pred_valid <= lk_valid && !flush;
            if (lk_valid) begin
                r_pred_taken <= w_lk_taken;
                r_pred_pc    <= lk_pc;
                r_pred_npc   <= w_lk_npc;
            end
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_taken;
    assign pred_pc    = r_pred_pc;
    assign pred_npc   = r_pred_npc;
    assign busy       = !w_idle;

`ifdef BTB_STATS_EN
    logic [31:0] r_stat_lookups, r_stat_hits, r_stat_mispred;
    logic        w_up_pred_taken, w_res_taken;
    logic [31:0] w_up_pred_npc, w_res_npc;

    // Kind 00 resolves as fall-through; jumps resolve taken regardless of upd_taken.
    assign w_up_pred_taken = w_up_hit && ((r_kind[w_up_idx] != 2'b01) || r_ctr[w_up_idx][1]);
    assign w_up_pred_npc   = w_up_pred_taken ? {r_target[w_up_idx], 2'b00} : upd_pc + 32'd4;
    assign w_res_taken     = upd_kind[1] || ((upd_kind == 2'b01) && upd_taken);
    assign w_res_npc       = w_res_taken ? {upd_target[31:2], 2'b00} : upd_pc + 32'd4;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stat_lookups <= '0;
            r_stat_hits    <= '0;
            r_stat_mispred <= '0;
        end else if (w_idle) begin
            if (lk_valid) r_stat_lookups <= r_stat_lookups + 32'd1;
            if (lk_valid && w_lk_hit) r_stat_hits <= r_stat_hits + 32'd1;
            if (w_upd_en && (w_res_npc != w_up_pred_npc)) r_stat_mispred <= r_stat_mispred + 32'd1;
        end
    end

    assign stat_lookups = r_stat_lookups;
    assign stat_hits    = r_stat_hits;
    assign stat_mispred = r_stat_mispred;
`endif
endmodule
